// File: rtl/act_sram_writer_pkg.sv
// Shared types and default geometry for the activation SRAM writer.
// The state encoding and the derived word/mask widths live here so the top and the packer agree on them.
package act_sram_writer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int CH_NUM_DEF       = 24;
   localparam int ACT_PER_ADDR_DEF = 4;
   localparam int BW_PER_ACT_DEF   = 16;
   localparam int ADDR_DEPTH_DEF   = 58101;

   localparam int WORD_W = CH_NUM_DEF * ACT_PER_ADDR_DEF * BW_PER_ACT_DEF;
   localparam int MASK_W = CH_NUM_DEF * ACT_PER_ADDR_DEF;

   // A slot counter needs at least one bit even when a word holds a single pixel.
   function automatic int slot_width(input int slots);
      return (slots > 1) ? $clog2(slots) : 1;
   endfunction

endpackage

// File: rtl/act_sram_writer_slot_packer.sv
// Combinational lane placement: merges one pixel beat into slot s of the word being assembled.
// Optional build macro ACT_SRAM_WRITER_RELU_EN clamps negative activations to zero before placement.
module act_slot_packer
   import act_sram_writer_pkg::*;
#(
   parameter int CH_NUM       = CH_NUM_DEF,
   parameter int ACT_PER_ADDR = ACT_PER_ADDR_DEF,
   parameter int BW_PER_ACT   = BW_PER_ACT_DEF,
   parameter int SLOT_W       = slot_width(ACT_PER_ADDR)
) (
   input  logic [CH_NUM*BW_PER_ACT-1:0]              beat,
   input  logic [SLOT_W-1:0]                         slot,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] word_in,
   input  logic [CH_NUM*ACT_PER_ADDR-1:0]            filled_in,
   output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] word_out,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]            filled_out
);

   logic [BW_PER_ACT-1:0] lane;
   int                    idx;

   // Channels of one pixel are interleaved ACT_PER_ADDR lanes apart so each channel's pixels sit together.
   always_comb begin
      word_out   = word_in;
      filled_out = filled_in;
      lane       = '0;
      idx        = 0;
      for (int c = 0; c < CH_NUM; c++) begin
         lane = beat[c*BW_PER_ACT +: BW_PER_ACT];
`ifdef ACT_SRAM_WRITER_RELU_EN
         if (lane[BW_PER_ACT-1]) begin
            lane = '0;
         end
`endif
         idx = c * ACT_PER_ADDR + int'(slot);
         word_out[idx*BW_PER_ACT +: BW_PER_ACT] = lane;
         filled_out[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/act_sram_writer.sv
// Packs a stream of pixel beats into wide SRAM words and issues one write strobe per word (partial flush on the last beat).
// Optional build macro ACT_SRAM_WRITER_RELU_EN (handled in act_slot_packer) zeroes negative activations; timing is identical either way.
module act_sram_writer
   import act_sram_writer_pkg::*;
#(
   parameter int CH_NUM       = CH_NUM_DEF,
   parameter int ACT_PER_ADDR = ACT_PER_ADDR_DEF,
   parameter int BW_PER_ACT   = BW_PER_ACT_DEF,
   parameter int ADDR_DEPTH   = ADDR_DEPTH_DEF
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      start,
   input  logic [15:0]                               base_addr,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [CH_NUM*BW_PER_ACT-1:0]              in_data,
   input  logic                                      in_last,
   output logic                                      sram_csb,
   output logic                                      sram_wsb,
   output logic [15:0]                               sram_waddr,
   output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]            sram_bytemask,
   output logic                                      busy,
   output logic                                      done,
   output logic [15:0]                               word_cnt
);

   localparam int W_WIDTH = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
   localparam int M_WIDTH = CH_NUM * ACT_PER_ADDR;
   localparam int SLOT_W  = slot_width(ACT_PER_ADDR);

   state_t               state;
   state_t               state_next;
   logic [SLOT_W-1:0]    slot;
   logic [W_WIDTH-1:0]   acc_word;
   logic [W_WIDTH-1:0]   packed_word;
   logic [W_WIDTH-1:0]   wdata_q;
   logic [M_WIDTH-1:0]   acc_filled;
   logic [M_WIDTH-1:0]   packed_filled;
   logic [15:0]          addr_q;
   logic [15:0]          cnt_q;
   logic                 last_q;
   logic                 accept;
   logic                 start_ok;
   logic                 word_full;

   assign accept    = in_valid && (state == FILL);
   assign start_ok  = start && (state == IDLE);
   assign word_full = accept && ((slot == SLOT_W'(ACT_PER_ADDR - 1)) || in_last);

   act_slot_packer #(
      .CH_NUM       (CH_NUM),
      .ACT_PER_ADDR (ACT_PER_ADDR),
      .BW_PER_ACT   (BW_PER_ACT),
      .SLOT_W       (SLOT_W)
   ) u_packer (
      .beat       (in_data),
      .slot       (slot),
      .word_in    (acc_word),
      .filled_in  (acc_filled),
      .word_out   (packed_word),
      .filled_out (packed_filled)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ok) state_next = FILL;
         FILL:    if (word_full) state_next = WRITE;
         WRITE:   state_next = last_q ? DONE : FILL;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // wdata_q is loaded only when a word completes so the SRAM bus stays put while the next word fills.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         slot       <= '0;
         acc_word   <= '0;
         acc_filled <= '0;
         wdata_q    <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            slot       <= '0;
            acc_filled <= '0;
            last_q     <= 1'b0;
            addr_q     <= base_addr;
            cnt_q      <= '0;
         end
         if (accept) begin
            acc_word   <= packed_word;
            acc_filled <= packed_filled;
            if (in_last) begin
               last_q <= 1'b1;
            end
            if (word_full) begin
               wdata_q <= packed_word;
            end else begin
               slot <= slot + SLOT_W'(1);
            end
         end
         if (state == WRITE) begin
            slot       <= '0;
            acc_filled <= '0;
            addr_q     <= (addr_q == 16'(ADDR_DEPTH - 1)) ? 16'd0 : addr_q + 16'd1;
            if (cnt_q != 16'hFFFF) begin
               cnt_q <= cnt_q + 16'd1;
            end
         end
      end
   end

   assign in_ready      = (state == FILL);
   assign sram_csb      = (state != WRITE);
   assign sram_wsb      = (state != WRITE);
   assign sram_waddr    = addr_q;
   assign sram_wdata    = wdata_q;
   assign sram_bytemask = (state == WRITE) ? ~acc_filled : {M_WIDTH{1'b1}};
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);
   assign word_cnt      = cnt_q;

endmodule

// File: doc/act_sram_writer.md
ACT_SRAM_WRITER -- requirements
Module: act_sram_writer

Interface
REQ-001 Parameter CH_NUM, default 24, channels per input beat.
REQ-002 Parameter ACT_PER_ADDR, default 4, pixel slots per SRAM word.
REQ-003 Parameter BW_PER_ACT, default 16, bits per activation (signed).
REQ-004 Parameter ADDR_DEPTH, default 58101, SRAM words; address range 0..ADDR_DEPTH-1.
REQ-005 One clock; reset is synchronous and active-low: ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock; SRAM samples on falling edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse that begins a layer write; ignored unless IDLE.
REQ-009 base_addr  input  16  first SRAM word address, sampled on accepted start.
REQ-010 in_valid / in_ready  input / output  1 / 1  activation beat handshake.
REQ-011 in_data  input  CH_NUM*BW_PER_ACT  one pixel, channel c at bits [c*BW_PER_ACT +: BW_PER_ACT].
REQ-012 in_last  input  1  marks final beat of the layer.
REQ-013 sram_csb, sram_wsb  output  1 each  active-low chip and write enables.
REQ-014 sram_waddr  output  16  write address.
REQ-015 sram_wdata  output  CH_NUM*ACT_PER_ADDR*BW_PER_ACT  packed word.
REQ-016 sram_bytemask  output  CH_NUM*ACT_PER_ADDR  1 = preserve stored activation, 0 = write.
REQ-017 busy  output  1  high outside IDLE; done  output  1  one-cycle pulse at layer end.
REQ-018 word_cnt  output  16  SRAM words written since last accepted start.

Function
REQ-019 FSM states IDLE, FILL, WRITE, DONE; IDLE->FILL on start, FILL->WRITE when slot ACT_PER_ADDR-1 filled or in_last accepted, WRITE->FILL (not last) or WRITE->DONE (last), DONE->IDLE after one cycle.
REQ-020 Beat transfers when in_valid && in_ready; in_ready is 1 only in FILL.
REQ-021 Slot counter s (0..ACT_PER_ADDR-1) resets to 0 on start and after each WRITE.
REQ-022 Channel c of beat in slot s is placed at word bits [(c*ACT_PER_ADDR+s)*BW_PER_ACT +: BW_PER_ACT], mask bit c*ACT_PER_ADDR+s.
REQ-023 In WRITE for exactly one cycle: sram_csb=0, sram_wsb=0, sram_waddr=current address, mask bit 0 for filled slots, 1 for unfilled slots (partial flush on in_last).
REQ-024 Outside WRITE: sram_csb=1, sram_wsb=1, sram_bytemask all ones, sram_wdata holds last value.
REQ-025 Latency: write strobe appears the cycle after the beat completing the word is accepted.
REQ-026 Address increments by 1 after each WRITE; after ADDR_DEPTH-1 wraps to 0.
REQ-027 word_cnt increments by 1 per WRITE, saturates at 16'hFFFF.
REQ-028 start during busy has no effect; in_valid in IDLE/WRITE/DONE is not accepted.
REQ-029 done asserts in DONE only; busy deasserts in the same cycle the FSM enters IDLE.

Reset
REQ-030 On rst_n=0 at rising clk: state IDLE, in_ready=0, sram_csb=1, sram_wsb=1, sram_bytemask all ones, sram_wdata=0, sram_waddr=0, word_cnt=0, busy=0, done=0.
REQ-031 Reset mid-layer discards the partial word; no write strobe is issued for it.

Configuration
REQ-032 Macro ACT_SRAM_WRITER_RELU_EN: when defined, each activation with sign bit 1 is replaced by 0 before packing; when undefined, activations are packed unmodified; timing identical in both builds.

Structure
REQ-033 Shared package holds FSM state enum, default CH_NUM/ACT_PER_ADDR/BW_PER_ACT/ADDR_DEPTH constants, and derived WORD_W/MASK_W widths.
REQ-034 One sub-module act_slot_packer: combinational lane placement of a beat into slot s with mask generation; FSM, counters and registers stay in act_sram_writer.

Verification
REQ-035 base_addr=100, 8 beats, in_last on beat 8 -> writes at 100,101, bytemask all zeros each, word_cnt=2, done once.
REQ-036 6 beats, in_last on beat 6 -> second write has slots 0-1 mask 0, slots 2-3 mask 1; word_cnt=2.
REQ-037 base_addr=58100, 8 beats -> writes at 58100 then 0.
REQ-038 in_data channel 0 = 16'hFFF0 with ACT_SRAM_WRITER_RELU_EN defined -> packed lane 16'h0000; undefined -> 16'hFFF0.
REQ-039 rst_n low after 3 beats of a word -> no write strobe, all outputs at reset values next cycle; new start at 200 writes first word to 200.
REQ-040 in_valid toggled randomly, start pulsed while busy -> no dropped or duplicated beats, base address unchanged.
